// File: rtl/trace_observer_pkg.sv
// Shared types and default parameters for the trace observer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package trace_observer_pkg;

    typedef logic [1:0] obs_t;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_RUN   = 2'd1,
        S_QUIET = 2'd2
    } state_e;

    localparam int DEPTH_DEF       = 4;
    localparam int MAX_STUTTER_DEF = 7;
    localparam int QUIET_LEN_DEF   = 3;

endpackage

// File: rtl/trace_observer_fifo.sv
// First-word-fall-through observation FIFO with wrap-bit full/empty.
// Latency: an entry pushed into an empty FIFO is visible at the head one cycle later.
// Backpressure: push while full is refused unless a pop occurs in the same cycle.
module obs_fifo
    import trace_observer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  obs_t push_dat_i,
    input  logic pop_i,
    output obs_t head_dat_o,
    output logic full_o,
    output logic empty_o,
    output logic push_ok_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    obs_t        mem_q [DEPTH];
    logic        do_pop, do_push;

    // Pointer arithmetic: a pop on an empty FIFO is ignored, a pop frees room for a push.
    always_comb begin
        empty_o    = (wr_q == rd_q);
        full_o     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop     = pop_i && !empty_o;
        do_push    = push_i && (!full_o || do_pop);
        push_ok_o  = do_push;
        wr_d       = do_push ? wr_q + 1'b1 : wr_q;
        rd_d       = do_pop  ? rd_q + 1'b1 : rd_q;
        head_dat_o = empty_o ? obs_t'(2'b00) : mem_q[rd_q[AW-1:0]];
    end

    // Pointer registers; reset empties the FIFO regardless of pending traffic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage array; contents are unreachable after reset so it needs no clear.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= push_dat_i;
        end
    end

endmodule

// File: rtl/trace_observer.sv
// Records changes of an upstream {a,b} trace into a FIFO and tracks quiescence/fairness.
// Latency: an event is visible on obs_valid/obs_data one cycle after it occurs.
// Backpressure: obs_ready gates pops; events arriving while full are dropped (sticky overflow).
// Optional fairness monitor enabled by defining TRACE_OBSERVER_FAIRNESS_EN.
module trace_observer
    import trace_observer_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEF,
    parameter int MAX_STUTTER = MAX_STUTTER_DEF,
    parameter int QUIET_LEN   = QUIET_LEN_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_in,
    input  logic       b_in,
    input  logic       stutter_in,
    input  logic       obs_ready,
    output logic       obs_valid,
    output logic [1:0] obs_data,
    output logic [3:0] obs_count,
    output logic       overflow,
    output logic       unfair,
    output logic       settled
);

    localparam int          QW   = $clog2(QUIET_LEN + 1);
    localparam logic [QW-1:0] QMAX = QW'(QUIET_LEN);

    state_e        state_q, state_d;
    obs_t          prev_q, prev_d;
    logic [QW-1:0] quiet_q, quiet_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    obs_t          ab_w;
    logic          event_w, pop_w, full_w, empty_w, push_ok_w;

    obs_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (event_w),
        .push_dat_i (ab_w),
        .pop_i      (pop_w),
        .head_dat_o (obs_data),
        .full_o     (full_w),
        .empty_o    (empty_w),
        .push_ok_o  (push_ok_w)
    );

    // Event detection, counters and state transitions; stutter cycles freeze the trace view.
    always_comb begin
        ab_w    = {a_in, b_in};
        event_w = !stutter_in && (ab_w != prev_q);
        pop_w   = obs_valid && obs_ready;
        prev_d  = event_w ? ab_w : prev_q;
        cnt_d   = (push_ok_w && cnt_q != 4'd15) ? cnt_q + 4'd1 : cnt_q;
        ovf_d   = ovf_q || (event_w && !push_ok_w);
        quiet_d = quiet_q;
        if (!stutter_in) begin
            if (event_w)             quiet_d = '0;
            else if (quiet_q != QMAX) quiet_d = quiet_q + 1'b1;
        end
        state_d = state_q;
        case (state_q)
            S_WAIT:  if (!stutter_in) state_d = S_RUN;
            S_RUN:   if (quiet_d >= QMAX) state_d = S_QUIET;
            S_QUIET: if (event_w) state_d = S_RUN;
            default: state_d = S_WAIT;
        endcase
    end

    // Core state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
            prev_q  <= '0;
            quiet_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            quiet_q <= quiet_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef TRACE_OBSERVER_FAIRNESS_EN
    localparam int            RW   = $clog2(MAX_STUTTER + 2);
    localparam logic [RW-1:0] RMAX = RW'(MAX_STUTTER + 1);

    logic [RW-1:0] run_q, run_d;
    logic          unfair_q, unfair_d;

    // Consecutive-stutter run length, saturating one past the legal limit.
    always_comb begin
        run_d    = stutter_in ? ((run_q == RMAX) ? run_q : run_q + 1'b1) : '0;
        unfair_d = unfair_q || (run_d == RMAX);
    end

    // Fairness registers; unfair is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= '0;
            unfair_q <= 1'b0;
        end else begin
            run_q    <= run_d;
            unfair_q <= unfair_d;
        end
    end

    assign unfair = unfair_q;
`else
    assign unfair = 1'b0;
`endif

    assign obs_valid = !empty_w;
    assign obs_count = cnt_q;
    assign overflow  = ovf_q;
    assign settled   = (state_q == S_QUIET);

endmodule

// File: tb/tb_trace_observer.sv
// Directed self-checking bench for trace_observer.
// Latency: inputs applied after a clock edge, outputs sampled 1 ns after the next edge.
// Backpressure: obs_ready driven per vector.
module tb_trace_observer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_in, b_in, stutter_in, obs_ready;
    logic       obs_valid;
    logic [1:0] obs_data;
    logic [3:0] obs_count;
    logic       overflow, unfair, settled;

    int checks = 0;
    int errors = 0;

    trace_observer #(.DEPTH(4), .MAX_STUTTER(7), .QUIET_LEN(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_in       (a_in),
        .b_in       (b_in),
        .stutter_in (stutter_in),
        .obs_ready  (obs_ready),
        .obs_valid  (obs_valid),
        .obs_data   (obs_data),
        .obs_count  (obs_count),
        .overflow   (overflow),
        .unfair     (unfair),
        .settled    (settled)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one vector and sample 1 ns after the following rising edge.
    task automatic cyc(input logic s, input logic [1:0] ab, input logic rdy);
        stutter_in = s;
        {a_in, b_in} = ab;
        obs_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        stutter_in = 1'b1;
        {a_in, b_in} = 2'b00;
        obs_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_valid", obs_valid, 0);
        chk("rst_data", obs_data, 0);
        chk("rst_count", obs_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unfair", unfair, 0);
        chk("rst_settled", settled, 0);

        // Quiet trace settles after three non-stutter, no-change cycles
        cyc(1'b0, 2'b00, 1'b1);
        chk("q1_settled", settled, 0);
        cyc(1'b0, 2'b00, 1'b1);
        chk("q2_settled", settled, 0);
        cyc(1'b0, 2'b00, 1'b1);
        chk("q3_settled", settled, 1);
        chk("q3_valid", obs_valid, 0);
        chk("q3_count", obs_count, 0);
        cyc(1'b1, 2'b10, 1'b1);
        chk("q_stut_settled", settled, 1);
        cyc(1'b0, 2'b01, 1'b0);
        chk("q_evt_settled", settled, 0);
        chk("q_evt_data", obs_data, 1);

        // Two events out of 01,01,11
        do_reset();
        cyc(1'b0, 2'b01, 1'b1);
        chk("s1_valid", obs_valid, 1);
        chk("s1_data", obs_data, 1);
        cyc(1'b0, 2'b01, 1'b1);
        chk("s2_valid", obs_valid, 0);
        cyc(1'b0, 2'b11, 1'b1);
        chk("s3_valid", obs_valid, 1);
        chk("s3_data", obs_data, 3);
        cyc(1'b0, 2'b11, 1'b1);
        chk("s4_valid", obs_valid, 0);
        chk("s4_count", obs_count, 2);

        // Fill, overflow, then simultaneous pop+push while full
        do_reset();
        cyc(1'b0, 2'b01, 1'b0);
        cyc(1'b0, 2'b10, 1'b0);
        cyc(1'b0, 2'b01, 1'b0);
        cyc(1'b0, 2'b10, 1'b0);
        chk("f4_count", obs_count, 4);
        chk("f4_ovf", overflow, 0);
        chk("f4_data", obs_data, 1);
        cyc(1'b0, 2'b01, 1'b0);
        chk("f5_count", obs_count, 4);
        chk("f5_ovf", overflow, 1);
        cyc(1'b0, 2'b10, 1'b1);
        chk("fpp_count", obs_count, 5);
        chk("fpp_ovf", overflow, 1);
        chk("fpp_data", obs_data, 2);
        begin
            logic [1:0] drain [3];
            drain[0] = 2'b01; drain[1] = 2'b10; drain[2] = 2'b10;
            for (int i = 0; i < 3; i++) begin
                cyc(1'b1, 2'b00, 1'b1);
                chk($sformatf("drain%0d_data", i), obs_data, int'(drain[i]));
            end
        end
        cyc(1'b1, 2'b00, 1'b1);
        chk("drain_empty", obs_valid, 0);
        chk("drain_ovf", overflow, 1);

        // Fairness monitor
        do_reset();
`ifdef TRACE_OBSERVER_FAIRNESS_EN
        for (int i = 0; i < 7; i++) cyc(1'b1, 2'b00, 1'b0);
        chk("fair7_unfair", unfair, 0);
        cyc(1'b0, 2'b00, 1'b0);
        chk("fair7b_unfair", unfair, 0);
        for (int i = 0; i < 7; i++) cyc(1'b1, 2'b00, 1'b0);
        chk("fair8a_unfair", unfair, 0);
        cyc(1'b1, 2'b00, 1'b0);
        chk("fair8_unfair", unfair, 1);
        cyc(1'b0, 2'b00, 1'b0);
        chk("fair8_sticky", unfair, 1);
`else
        for (int i = 0; i < 8; i++) cyc(1'b1, 2'b00, 1'b0);
        chk("nofair_unfair", unfair, 0);
`endif

        // Value carried on a stutter cycle is ignored
        do_reset();
        cyc(1'b1, 2'b10, 1'b1);
        cyc(1'b0, 2'b00, 1'b1);
        chk("stut_valid", obs_valid, 0);
        chk("stut_count", obs_count, 0);
        cyc(1'b0, 2'b10, 1'b0);
        chk("stut_evt_data", obs_data, 2);

        // Reset while entries are queued
        do_reset();
        cyc(1'b0, 2'b01, 1'b0);
        cyc(1'b0, 2'b10, 1'b0);
        cyc(1'b0, 2'b01, 1'b0);
        chk("r3_count", obs_count, 3);
        rst_n = 1'b0;
        #1;
        chk("ra_valid", obs_valid, 0);
        chk("ra_count", obs_count, 0);
        chk("ra_data", obs_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b0, 2'b00, 1'b0);
        chk("r00_valid", obs_valid, 0);
        chk("r00_count", obs_count, 0);
        cyc(1'b0, 2'b11, 1'b0);
        chk("r11_data", obs_data, 3);
        chk("r11_count", obs_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_observer.md
TRACE_OBSERVER -- requirements
Module: trace_observer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the observation FIFO depth (power of two, 2..16).
REQ-002 Parameter MAX_STUTTER, default 7, SHALL set the longest legal consecutive stutter run in cycles.
REQ-003 Parameter QUIET_LEN, default 3, SHALL set the consecutive non-stutter, no-change cycles needed to declare settled.
REQ-004 Clock and reset SHALL be one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-005 Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- a_in  in  1  upstream codeblock output a
- b_in  in  1  upstream codeblock output b
- stutter_in  in  1  upstream stutter flag; values ignored when 1
- obs_ready  in  1  consumer accepts head entry
- obs_valid  out  1  FIFO non-empty
- obs_data  out  2  head entry {a,b}
- obs_count  out  4  accepted events, saturating
- overflow  out  1  sticky: event dropped
- unfair  out  1  sticky: stutter run exceeded MAX_STUTTER
- settled  out  1  trace quiescent

Function
REQ-006 The block SHALL hold prev_obs (2 bits), reset value 2'b00, equal to the upstream block's initial outputs.
REQ-007 An event SHALL occur in a cycle where stutter_in=0 and {a_in,b_in} != prev_obs; prev_obs SHALL then load {a_in,b_in}.
REQ-008 With stutter_in=1, the block SHALL leave prev_obs, the FIFO push side, and the quiet counter unchanged.
REQ-009 Each event SHALL push {a_in,b_in}; obs_valid SHALL rise the cycle after the push into an empty FIFO (latency 1).
REQ-010 obs_data SHALL present the head entry first-word-fall-through; a pop SHALL occur when obs_valid and obs_ready.
REQ-011 A push while full SHALL be dropped and set overflow, unless a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-012 Simultaneous push and pop on an empty FIFO SHALL store the pushed entry; the pop SHALL be ignored.
REQ-013 Read/write pointers SHALL wrap modulo DEPTH; full/empty SHALL use an extra wrap bit.
REQ-014 obs_count SHALL increment on each accepted push and saturate at 15.
REQ-015 State machine: S_WAIT (reset) -> S_RUN on the first stutter_in=0 cycle; S_RUN -> S_QUIET after QUIET_LEN consecutive non-stutter cycles without an event; S_QUIET -> S_RUN on an event.
REQ-016 The quiet counter SHALL clear on any event and hold during stutter cycles.
REQ-017 settled SHALL be 1 exactly in S_QUIET.

Reset
REQ-018 Asserting rst_n=0 SHALL immediately clear state to S_WAIT, pointers, prev_obs, counters, overflow, unfair, obs_valid, obs_data, settled, and obs_count to 0, discarding FIFO contents, including during a pending push or pop.
REQ-019 The first event after reset release SHALL be evaluated against prev_obs=2'b00.

Configuration
REQ-020 With TRACE_OBSERVER_FAIRNESS_EN defined, a run counter SHALL count consecutive stutter_in=1 cycles, clear on stutter_in=0, and saturate at MAX_STUTTER+1; unfair SHALL set when it reaches MAX_STUTTER+1.
REQ-021 Without TRACE_OBSERVER_FAIRNESS_EN, the run counter SHALL be absent and unfair SHALL be constant 0.

Structure
REQ-022 Package trace_observer_pkg SHALL hold typedef obs_t (2 bits), the state enum (S_WAIT, S_RUN, S_QUIET), and the default DEPTH, MAX_STUTTER, and QUIET_LEN constants.
REQ-023 The FIFO SHALL be sub-module obs_fifo (parameterised by DEPTH, with push/pop/full/empty); the event detector, state machine, and counters SHALL reside in trace_observer.

Verification
REQ-024 Reset; hold stutter_in=0 with a_in/b_in=0,0 for 3 cycles -> no push; settled=1 on cycle 3; obs_count=0.
REQ-025 Sequence {a,b}=01,01,11 with stutter_in=0 and obs_ready=1 -> exactly two entries, 01 then 11; obs_count=2.
REQ-026 obs_ready=0, DEPTH=4, 5 events -> 4 stored; overflow=1; then pop and push in the same cycle while full -> accepted; overflow stays 1.
REQ-027 With FAIRNESS_EN, stutter_in=1 for 8 cycles -> unfair=1 at cycle 8; with 7 cycles followed by a 0 -> unfair=0.
REQ-028 Stutter cycle carrying {a,b}=10 followed by a non-stutter cycle with 00 -> no event.
REQ-029 rst_n pulse while 3 entries are queued -> obs_valid=0 immediately; the first later event of 00 is not pushed.
